// File: rtl/fb_pkg.sv
// Shared constants and FSM encoding for the frame-buffer line arbiter.
package fb_pkg;
    localparam int LINE_W = 640;
    localparam int LINES  = 480;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam int X_W    = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/fb_addr_gen.sv
// Scanline read address generator: line base by shift-add plus pixel index counter.
module fb_addr_gen
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [8:0]        line,
    output logic [ADDR_W-1:0] next_addr,
    output logic [X_W-1:0]    x,
    output logic              last
);
    logic [ADDR_W-1:0] base_s;
    logic [ADDR_W-1:0] base_r;
    logic [X_W-1:0]    x_r;

    // line * 640 = (line << 9) + (line << 7)
    always_comb begin
        base_s = ({10'd0, line} << 9) + ({10'd0, line} << 7);
    end

    // Base of the line being fetched and index of the read currently on the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_r <= '0;
            x_r    <= '0;
        end else if (load) begin
            base_r <= base_s;
            x_r    <= '0;
        end else if (step) begin
            x_r <= x_r + 10'd1;
        end
    end

    // Address to present on the next cycle: first pixel on load, otherwise the following pixel.
    always_comb begin
        if (load) begin
            next_addr = base_s;
        end else begin
            next_addr = base_r + {9'd0, x_r} + 19'd1;
        end
        x    = x_r;
        last = (x_r == X_W'(LINE_W - 1));
    end
endmodule

// File: rtl/fb_line_arbiter.sv
// Frame-buffer arbiter: scanline fetch into the line buffer has absolute
// priority; renderer writes use the remaining memory cycles.
module fb_line_arbiter
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [8:0]        fetch_line,
    output logic              fetch_done,
    output logic              fetch_err,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic [X_W-1:0]    lb_addr,
    output logic [DATA_W-1:0] lb_wdata
);
    state_t            state_r;
    state_t            state_s;
    logic              drain_r;
    logic              drain_s;
    logic              accept_s;
    logic              drop_s;
    logic              fire_s;
    logic              step_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic [X_W-1:0]    x_s;
    logic              last_s;
    logic              re_d1_r;
    logic [X_W-1:0]    idx_d1_r;

    fb_addr_gen u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (accept_s),
        .step      (step_s),
        .line      (fetch_line),
        .next_addr (next_addr_s),
        .x         (x_s),
        .last      (last_s)
    );

    // Next-state logic, request arbitration and write handshake.
    always_comb begin
        state_s  = state_r;
        drain_s  = 1'b0;
        accept_s = fetch_req && (state_r == IDLE) && (fetch_line < 9'(LINES));
        drop_s   = fetch_req && !accept_s;
        wr_ready = !reset && !fetch_req && (state_r != FETCH);
        fire_s   = wr_valid && wr_ready;
        step_s   = (state_r == FETCH) && !last_s;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = FETCH;
                else          state_s = IDLE;
            end
            FETCH: begin
                if (last_s) state_s = DRAIN;
                else        state_s = FETCH;
            end
            DRAIN: begin
                if (drain_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                    drain_s = 1'b1;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            drain_r <= 1'b0;
        end else begin
            state_r <= state_s;
            drain_r <= drain_s;
        end
    end

    // Registered memory strobes, line-buffer pipeline and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            re_d1_r    <= 1'b0;
            idx_d1_r   <= '0;
            lb_we      <= 1'b0;
            lb_addr    <= '0;
            lb_wdata   <= '0;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            mem_re <= accept_s || step_s;
            mem_we <= fire_s;
            if (accept_s || step_s) begin
                mem_addr <= next_addr_s;
            end else if (fire_s) begin
                mem_addr <= wr_addr;
            end
            if (fire_s) begin
                mem_wdata <= wr_data;
            end
            // Read data arrives one cycle after mem_re; track its pixel index alongside.
            re_d1_r  <= mem_re;
            idx_d1_r <= x_s;
            lb_we    <= re_d1_r;
            if (re_d1_r) begin
                lb_addr  <= idx_d1_r;
                lb_wdata <= mem_rdata;
            end
            fetch_done <= re_d1_r && (idx_d1_r == X_W'(LINE_W - 1));
            fetch_err  <= fetch_err || drop_s;
        end
    end
endmodule

// File: tb/tb_fb_line_arbiter.sv
// Self-checking bench for fb_line_arbiter: randomized traffic compared per
// cycle against a timeline model of fetches, writes and error flag.
module tb_fb_line_arbiter;
    import fb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [8:0]  fetch_line;
    logic        fetch_done;
    logic        fetch_err;
    logic        wr_valid;
    logic        wr_ready;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic [18:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        lb_we;
    logic [9:0]  lb_addr;
    logic [7:0]  lb_wdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] seed8 = 8'h00;

    // model state: start cycle/base of the last accepted fetch, last reset cycle
    int          fs = -100000;
    int          rst_cut = -1;
    logic [18:0] fb = 19'd0;
    bit          err = 1'b0;
    bit          pw_fire = 1'b0;
    logic [18:0] pw_addr = 19'd0;
    logic [7:0]  pw_data = 8'd0;

    bit          exp_re, exp_lbwe, exp_done, exp_we, exp_err, exp_ready;
    logic [18:0] exp_raddr, exp_waddr;
    logic [9:0]  exp_lbaddr;
    logic [7:0]  exp_lbdata, exp_wdata;

    fb_line_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .fetch_line (fetch_line),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .lb_we      (lb_we),
        .lb_addr    (lb_addr),
        .lb_wdata   (lb_wdata)
    );

    always #10 clk = ~clk;

    function automatic logic [7:0] pix(input logic [18:0] a, input logic [7:0] s);
        return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ s;
    endfunction

    // Frame-buffer SRAM: data valid exactly one cycle after mem_re, garbage otherwise.
    always @(posedge clk) begin
        mem_rdata <= mem_re ? pix(mem_addr, seed8) : 8'hEE;
    end

    task automatic model_step();
        int k;
        bit live, in_f, busy;
        k    = cyc - fs;
        live = (fs > rst_cut);
        in_f = live && k >= 1 && k <= LINE_W;
        busy = live && k >= 1 && k <= LINE_W + 2;
        exp_re     = in_f;
        exp_raddr  = fb + 19'(k - 1);
        exp_lbwe   = live && k >= 3 && k <= LINE_W + 2;
        exp_lbaddr = 10'(k - 3);
        exp_lbdata = pix(fb + 19'(k - 3), seed8);
        exp_done   = live && k == LINE_W + 2;
        exp_we     = pw_fire;
        exp_waddr  = pw_addr;
        exp_wdata  = pw_data;
        exp_err    = err;
        exp_ready  = !reset && !fetch_req && !in_f;
        if (reset) begin
            rst_cut = cyc;
            err     = 1'b0;
            pw_fire = 1'b0;
        end else begin
            pw_fire = wr_valid && exp_ready;
            pw_addr = wr_addr;
            pw_data = wr_data;
            if (fetch_req) begin
                if (!busy && fetch_line < LINES) begin
                    fs = cyc;
                    fb = 19'(fetch_line * LINE_W);
                end else begin
                    err = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(input logic rst, input logic req, input logic [8:0] line,
                         input logic wv, input logic [18:0] wa, input logic [7:0] wd);
        reset = rst; fetch_req = req; fetch_line = line;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        model_step();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        drive(1'b1, 1'b0, 9'd0, 1'b0, 19'd0, 8'd0);
        tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 9'd0, 1'b1, 19'h1234, 8'h77);
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if ({mem_re, mem_we, lb_we, fetch_done, fetch_err, wr_ready} !== 6'd0) begin
                    failures++;
                    $display("FAIL rst_strobes got=%b exp=000000", {mem_re, mem_we, lb_we, fetch_done, fetch_err, wr_ready});
                end
                checks++;
                if ({mem_addr, mem_wdata, lb_addr, lb_wdata} !== 45'd0) begin
                    failures++;
                    $display("FAIL rst_buses got=%h exp=0", {mem_addr, mem_wdata, lb_addr, lb_wdata});
                end
            end
            tick();
        end
    endtask

    task automatic test_single_fetch();
        seed8 = 8'($urandom);
        for (int i = 0; i < 650; i++) begin
            drive(1'b0, i == 0, 9'd2, 1'b0, 19'd0, 8'd0);
            @(negedge clk);
            checks++;
            if (mem_re !== exp_re) begin failures++; $display("FAIL sf_re i=%0d got=%b exp=%b", i, mem_re, exp_re); end
            if (exp_re) begin
                checks++;
                if (mem_addr !== exp_raddr) begin failures++; $display("FAIL sf_addr i=%0d got=%0d exp=%0d", i, mem_addr, exp_raddr); end
            end
            checks++;
            if (lb_we !== exp_lbwe) begin failures++; $display("FAIL sf_lbwe i=%0d got=%b exp=%b", i, lb_we, exp_lbwe); end
            if (exp_lbwe) begin
                checks++;
                if ({lb_addr, lb_wdata} !== {exp_lbaddr, exp_lbdata}) begin
                    failures++; $display("FAIL sf_lb i=%0d got=%0d/%h exp=%0d/%h", i, lb_addr, lb_wdata, exp_lbaddr, exp_lbdata);
                end
            end
            checks++;
            if ({fetch_done, mem_we} !== {exp_done, 1'b0}) begin
                failures++; $display("FAIL sf_done_we i=%0d got=%b%b exp=%b0", i, fetch_done, mem_we, exp_done);
            end
            tick();
        end
    endtask

    task automatic test_last_line();
        seed8 = 8'($urandom);
        for (int i = 0; i < 670; i++) begin
            drive(1'b0, (i == 0) || (i == 650), (i < 650) ? 9'd479 : 9'd480, 1'b0, 19'd0, 8'd0);
            @(negedge clk);
            checks++;
            if (mem_re !== exp_re) begin failures++; $display("FAIL ll_re i=%0d got=%b exp=%b", i, mem_re, exp_re); end
            if (exp_re) begin
                checks++;
                if (mem_addr !== exp_raddr) begin failures++; $display("FAIL ll_addr i=%0d got=%0d exp=%0d", i, mem_addr, exp_raddr); end
            end
            checks++;
            if (fetch_err !== exp_err) begin failures++; $display("FAIL ll_err i=%0d got=%b exp=%b", i, fetch_err, exp_err); end
            checks++;
            if (fetch_done !== exp_done) begin failures++; $display("FAIL ll_done i=%0d got=%b exp=%b", i, fetch_done, exp_done); end
            tick();
        end
    endtask

    task automatic test_contention();
        logic [8:0] ln;
        ln = 9'($urandom_range(479, 0));
        apply_reset();
        for (int i = 0; i < 670; i++) begin
            drive(1'b0, i == 10, ln, 1'b1, 19'd100, 8'h5A);
            @(negedge clk);
            checks++;
            if (wr_ready !== exp_ready) begin failures++; $display("FAIL ct_ready i=%0d got=%b exp=%b", i, wr_ready, exp_ready); end
            checks++;
            if (mem_we !== exp_we) begin failures++; $display("FAIL ct_we i=%0d got=%b exp=%b", i, mem_we, exp_we); end
            if (exp_we) begin
                checks++;
                if ({mem_addr, mem_wdata} !== {exp_waddr, exp_wdata}) begin
                    failures++; $display("FAIL ct_wr i=%0d got=%0d/%h exp=%0d/%h", i, mem_addr, mem_wdata, exp_waddr, exp_wdata);
                end
            end
            checks++;
            if (mem_re !== exp_re) begin failures++; $display("FAIL ct_re i=%0d got=%b exp=%b", i, mem_re, exp_re); end
            checks++;
            if (mem_re && mem_we) begin failures++; $display("FAIL ct_both i=%0d got=11 exp=not both", i); end
            tick();
        end
    endtask

    task automatic test_overrun();
        seed8 = 8'($urandom);
        for (int i = 0; i < 700; i++) begin
            drive(1'b0, (i == 0) || (i == 300), 9'($urandom_range(479, 0)), 1'b0, 19'd0, 8'd0);
            @(negedge clk);
            checks++;
            if (mem_re !== exp_re) begin failures++; $display("FAIL ov_re i=%0d got=%b exp=%b", i, mem_re, exp_re); end
            checks++;
            if (lb_we !== exp_lbwe) begin failures++; $display("FAIL ov_lbwe i=%0d got=%b exp=%b", i, lb_we, exp_lbwe); end
            if (exp_lbwe) begin
                checks++;
                if ({lb_addr, lb_wdata} !== {exp_lbaddr, exp_lbdata}) begin
                    failures++; $display("FAIL ov_lb i=%0d got=%0d/%h exp=%0d/%h", i, lb_addr, lb_wdata, exp_lbaddr, exp_lbdata);
                end
            end
            checks++;
            if ({fetch_done, fetch_err} !== {exp_done, exp_err}) begin
                failures++; $display("FAIL ov_done_err i=%0d got=%b%b exp=%b%b", i, fetch_done, fetch_err, exp_done, exp_err);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        seed8 = 8'($urandom);
        for (int i = 0; i < 860; i++) begin
            drive(i == 200, (i == 0) || (i == 210), 9'($urandom_range(479, 0)), 1'b0, 19'd0, 8'd0);
            @(negedge clk);
            checks++;
            if ({mem_re, lb_we, fetch_done, fetch_err} !== {exp_re, exp_lbwe, exp_done, exp_err}) begin
                failures++;
                $display("FAIL rm_flags i=%0d got=%b%b%b%b exp=%b%b%b%b", i, mem_re, lb_we, fetch_done, fetch_err,
                         exp_re, exp_lbwe, exp_done, exp_err);
            end
            if (exp_re) begin
                checks++;
                if (mem_addr !== exp_raddr) begin failures++; $display("FAIL rm_addr i=%0d got=%0d exp=%0d", i, mem_addr, exp_raddr); end
            end
            if (exp_lbwe) begin
                checks++;
                if ({lb_addr, lb_wdata} !== {exp_lbaddr, exp_lbdata}) begin
                    failures++; $display("FAIL rm_lb i=%0d got=%0d/%h exp=%0d/%h", i, lb_addr, lb_wdata, exp_lbaddr, exp_lbdata);
                end
            end
            if (i == 201) begin
                checks++;
                if ({mem_addr, lb_addr, mem_we} !== 30'd0) begin
                    failures++; $display("FAIL rm_zero got=%h exp=0", {mem_addr, lb_addr, mem_we});
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int ndone, first, second;
        ndone = 0; first = -1; second = -1;
        seed8 = 8'($urandom);
        apply_reset();
        for (int i = 0; i < 1300; i++) begin
            drive(1'b0, (i == 0) || (i == 643), 9'($urandom_range(479, 0)),
                  1'($urandom), 19'($urandom_range(307199, 0)), 8'($urandom));
            @(negedge clk);
            checks++;
            if ({mem_re, mem_we, wr_ready} !== {exp_re, exp_we, exp_ready}) begin
                failures++; $display("FAIL bb_strobes i=%0d got=%b%b%b exp=%b%b%b", i, mem_re, mem_we, wr_ready, exp_re, exp_we, exp_ready);
            end
            if (exp_re || exp_we) begin
                checks++;
                if (mem_addr !== (exp_re ? exp_raddr : exp_waddr)) begin
                    failures++; $display("FAIL bb_addr i=%0d got=%0d exp=%0d", i, mem_addr, exp_re ? exp_raddr : exp_waddr);
                end
            end
            if (exp_we) begin
                checks++;
                if (mem_wdata !== exp_wdata) begin failures++; $display("FAIL bb_wdata i=%0d got=%h exp=%h", i, mem_wdata, exp_wdata); end
            end
            if (exp_lbwe) begin
                checks++;
                if ({lb_we, lb_addr, lb_wdata} !== {1'b1, exp_lbaddr, exp_lbdata}) begin
                    failures++; $display("FAIL bb_lb i=%0d got=%b/%0d/%h exp=1/%0d/%h", i, lb_we, lb_addr, lb_wdata, exp_lbaddr, exp_lbdata);
                end
            end
            checks++;
            if ({fetch_done, fetch_err} !== {exp_done, exp_err}) begin
                failures++; $display("FAIL bb_done_err i=%0d got=%b%b exp=%b%b", i, fetch_done, fetch_err, exp_done, exp_err);
            end
            if (fetch_done === 1'b1) begin
                ndone++;
                if (first < 0) first = i;
                else second = i;
            end
            tick();
        end
        checks++;
        if (ndone != 2 || (second - first) != 643) begin
            failures++; $display("FAIL bb_spacing got=%0d pulses gap %0d exp=2 pulses gap 643", ndone, second - first);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_last_line();
        test_contention();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
